background_gen: RTL and testbench

Parametrised pipelined background generator for the VGA pixel path. It produces a per-pixel 24-bit background colour from the spot coordinates. Four selectable patterns are supported: horizontal, vertical and diagonal gradients, plus scrolling bands. Colour, mode and scroll-speed inputs are shadowed at frame start so the picture never tears. Output feeds the sprite/overlay mixer two cycles after the coordinates arrive.

---
 rtl/background_gen_if.sv | 30 +++
 rtl/background_gen.sv | 130 +++++++++++++
 tb/tb_background_gen.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/background_gen_if.sv
// background_gen_if -- pixel-path bundle between the timing generator and the
// background generator.
//   spotX/spotY       : signed current pixel column / line
//   frame_start       : one-cycle pulse before the first active pixel of a frame
//   mode/step         : pattern select and per-frame scroll increment
//   bck_r/bck_g/bck_b : base colour components
//   bck_rgb/bck_valid : generated colour {r,g,b} and active-pixel flag
// master = pixel source (drives coordinates/controls), slave = generator.
interface background_gen_if;
   logic signed [10:0] spotX;
   logic signed [10:0] spotY;
   logic               frame_start;
   logic [1:0]         mode;
   logic [3:0]         step;
   logic [7:0]         bck_r;
   logic [7:0]         bck_g;
   logic [7:0]         bck_b;
   logic [23:0]        bck_rgb;
   logic               bck_valid;

   modport master (
      output spotX, spotY, frame_start, mode, step, bck_r, bck_g, bck_b,
      input  bck_rgb, bck_valid
   );

   modport slave (
      input  spotX, spotY, frame_start, mode, step, bck_r, bck_g, bck_b,
      output bck_rgb, bck_valid
   );
endinterface

// File: rtl/background_gen.sv
// background_gen -- two-stage pipelined background colour generator.
// Produces a 24-bit colour per pixel from the spot coordinates using one of
// four patterns (horizontal / vertical / diagonal gradient, scrolling bands).
// Controls and colours are shadowed on frame_start so a frame never tears.
// Ports:
//   clk     : pixel clock
//   reset_n : asynchronous active-low reset
//   bus     : background_gen_if.slave (coordinates, controls, colour out)
// Latency: coordinates at edge N+1 -> bck_rgb/bck_valid at edge N+2.
module background_gen #(
   parameter int HACTIVE   = 800,
   parameter int VACTIVE   = 600,
   parameter int SHIFT     = 2,
   parameter int BAND_LOG2 = 6,
   parameter int OFFSET_W  = 10   // must not exceed 12 (distance width)
) (
   input  logic            clk,
   input  logic            reset_n,
   background_gen_if.slave bus
);

   localparam int NUM_CH = 3;
   localparam logic signed [11:0] HMAX  = 12'(HACTIVE);
   localparam logic signed [11:0] VMAX  = 12'(VACTIVE);
   localparam logic [11:0]        HLAST = 12'(HACTIVE - 1);
   localparam logic [11:0]        VLAST = 12'(VACTIVE - 1);
   localparam logic [11:0]        PH_MASK = 12'((1 << BAND_LOG2) - 1);

   // ---------------- frame shadows ----------------
   logic [1:0]                    r_mode;
   logic [3:0]                    r_step;
   logic [NUM_CH-1:0][7:0]        r_col;
   logic [OFFSET_W-1:0]           r_offset;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mode   <= '0;
         r_step   <= '0;
         r_col    <= '0;
         r_offset <= '0;
      end else if (bus.frame_start) begin
         r_mode   <= bus.mode;
         r_step   <= bus.step;
         r_col    <= {bus.bck_r, bus.bck_g, bus.bck_b};
         // advance by the step that was in force during the finished frame;
         // wraps silently at 2^OFFSET_W
         r_offset <= r_offset + OFFSET_W'(r_step);
      end
   end

   // ---------------- stage 1: distance + active ----------------
   logic signed [11:0] w_xs, w_ys;
   logic [11:0]        w_xu, w_yu;
   logic               w_active;
   logic [11:0]        w_dx, w_dy, w_d2, w_d3, w_xo, w_d;
   logic [12:0]        w_sum;

   assign w_xs     = {bus.spotX[10], bus.spotX};
   assign w_ys     = {bus.spotY[10], bus.spotY};
   assign w_xu     = w_xs;
   assign w_yu     = w_ys;
   assign w_active = (w_xs >= 12'sd0) && (w_xs < HMAX) &&
                     (w_ys >= 12'sd0) && (w_ys < VMAX);

   assign w_dx  = HLAST - w_xu;
   assign w_dy  = VLAST - w_yu;
   assign w_sum = {1'b0, w_dx} + {1'b0, w_dy};
   assign w_d2  = 12'(w_sum >> 1);
   // band phase is pre-scaled by SHIFT so stage 2 recovers the raw phase
   assign w_xo  = w_xu + 12'(r_offset);
   assign w_d3  = (w_xo & PH_MASK) << SHIFT;

   always_comb begin
      w_d = '0;
      if (w_active) begin
         case (r_mode)
            2'd0:    w_d = w_dx;
            2'd1:    w_d = w_dy;
            2'd2:    w_d = w_d2;
            default: w_d = w_d3;
         endcase
      end
   end

   logic [11:0]            r_d1;
   logic [NUM_CH-1:0][7:0] r_col1;
   logic [2:1]             r_vld_pipe;

   // colours travel with the pixel so a pixel sampled on the frame_start
   // cycle still finishes with the previous frame's colours
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_d1          <= '0;
         r_col1        <= '0;
         r_vld_pipe[1] <= 1'b0;
      end else begin
         r_d1          <= w_d;
         r_col1        <= r_col;
         r_vld_pipe[1] <= w_active;
      end
   end

   // ---------------- stage 2: saturating subtract ----------------
   logic [11:0]            w_sh;
   logic [7:0]             w_s;
   logic [NUM_CH-1:0][7:0] w_sub;

   assign w_sh = r_d1 >> SHIFT;
   assign w_s  = (|w_sh[11:8]) ? 8'hFF : w_sh[7:0];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign w_sub[c] = (r_col1[c] > w_s) ? (r_col1[c] - w_s) : 8'd0;
   end

   logic [NUM_CH-1:0][7:0] r_rgb;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rgb         <= '0;
         r_vld_pipe[2] <= 1'b0;
      end else begin
         r_rgb         <= r_vld_pipe[1] ? w_sub : '0;
         r_vld_pipe[2] <= r_vld_pipe[1];
      end
   end

   assign bus.bck_rgb   = r_rgb;
   assign bus.bck_valid = r_vld_pipe[2];

endmodule

// File: tb/tb_background_gen.sv
module tb_background_gen;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   background_gen_if bif();

   background_gen #(
      .HACTIVE(800), .VACTIVE(600), .SHIFT(2), .BAND_LOG2(6), .OFFSET_W(10)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bif.slave)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // one pixel in flight: expectation of the previous tick is checked at the
   // end of the current one (two rising edges after it was driven)
   bit          pend_chk = 0;
   logic [23:0] pend_rgb = '0;
   bit          pend_vld = 0;
   string       pend_tag = "";

   task automatic tick(input int x, input int y, input bit fs, input bit chk_en,
                       input logic [23:0] erg, input bit ev, input string tag);
      bif.spotX       = 11'(x);
      bif.spotY       = 11'(y);
      bif.frame_start = fs;
      @(posedge clk);
      @(negedge clk);
      bif.frame_start = 1'b0;
      if (pend_chk) begin
         check({pend_tag, "_rgb"}, 32'(bif.bck_rgb), 32'(pend_rgb));
         check({pend_tag, "_vld"}, 32'(bif.bck_valid), 32'(pend_vld));
      end
      pend_chk = chk_en;
      pend_rgb = erg;
      pend_vld = ev;
      pend_tag = tag;
   endtask

   task automatic set_ctl(input logic [1:0] m, input logic [3:0] st,
                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      bif.mode  = m;
      bif.step  = st;
      bif.bck_r = r;
      bif.bck_g = g;
      bif.bck_b = b;
   endtask

   initial begin
      bif.spotX = '0; bif.spotY = '0; bif.frame_start = 1'b0;
      set_ctl(2'd0, 4'd0, 8'h00, 8'h00, 8'h00);
      repeat (2) @(negedge clk);
      check("reset_rgb", 32'(bif.bck_rgb), 32'h0);
      check("reset_vld", 32'(bif.bck_valid), 32'h0);
      reset_n = 1'b1;

      // shadows are zero: active pixel is black but valid
      tick(799, 0, 0, 1, 24'h000000, 1, "post_reset");

      // ---- mode 0 ----
      set_ctl(2'd0, 4'd0, 8'hFF, 8'h80, 8'h10);
      tick(799, 0, 1, 1, 24'h000000, 1, "m0_fs_old");
      tick(799, 0, 0, 1, 24'hFF8010, 1, "m0_x799");
      tick(0,   0, 0, 1, 24'h380000, 1, "m0_x0");
      tick(400, 300, 0, 1, 24'h9C1D00, 1, "m0_x400");
      tick(-1,  0, 0, 1, 24'h000000, 0, "inact_xm1");
      tick(800, 0, 0, 1, 24'h000000, 0, "inact_x800");
      tick(799, 600, 0, 1, 24'h000000, 0, "inact_y600");
      tick(799, -1, 0, 1, 24'h000000, 0, "inact_ym1");
      // alternating active / inactive, back to back
      tick(799, 0, 0, 1, 24'hFF8010, 1, "alt0");
      tick(800, 5, 0, 1, 24'h000000, 0, "alt1");
      tick(798, 5, 0, 1, 24'hFF8010, 1, "alt2");
      tick(-1,  5, 0, 1, 24'h000000, 0, "alt3");
      tick(795, 5, 0, 1, 24'hFE7F0F, 1, "alt4");

      // ---- mode 1 ----
      set_ctl(2'd1, 4'd0, 8'hFF, 8'h80, 8'h10);
      tick(0, 0, 1, 1, 24'h380000, 1, "m1_fs_old");
      tick(5, 599, 0, 1, 24'hFF8010, 1, "m1_y599");
      tick(5, 0,   0, 1, 24'h6A0000, 1, "m1_y0");
      tick(5, 600, 0, 1, 24'h000000, 0, "m1_y600");

      // ---- mode 2 ----
      set_ctl(2'd2, 4'd0, 8'hFF, 8'h80, 8'h10);
      tick(5, 599, 1, 1, 24'hFF8010, 1, "m2_fs_old");
      tick(0, 0,     0, 1, 24'h510000, 1, "m2_00");
      tick(799, 599, 0, 1, 24'hFF8010, 1, "m2_corner");
      tick(700, 500, 0, 1, 24'hE76800, 1, "m2_mid");

      // ---- shadowing: mid-frame changes ignored until frame_start ----
      set_ctl(2'd0, 4'd0, 8'h40, 8'h40, 8'h40);
      tick(799, 599, 0, 1, 24'hFF8010, 1, "shd_hold0");
      tick(0, 0,     0, 1, 24'h510000, 1, "shd_hold1");
      tick(0, 0,     1, 1, 24'h510000, 1, "shd_fs_old");
      tick(799, 0,   0, 1, 24'h404040, 1, "shd_new");
      tick(799, 0,   0, 0, 24'h000000, 0, "flush");

      // ---- asynchronous reset mid-stream ----
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_rgb", 32'(bif.bck_rgb), 32'h0);
      check("async_rst_vld", 32'(bif.bck_valid), 32'h0);
      @(negedge clk);
      reset_n  = 1'b1;
      pend_chk = 0;
      tick(799, 0,   0, 1, 24'h000000, 1, "rst_shadow0");
      tick(400, 300, 0, 1, 24'h000000, 1, "rst_shadow1");

      // ---- mode 3 scrolling bands, step 5 ----
      set_ctl(2'd3, 4'd5, 8'h80, 8'h80, 8'h80);
      tick(799, 0, 1, 1, 24'h000000, 1, "m3_fs1_old");   // step 5, offset 0
      tick(0,  0, 0, 1, 24'h808080, 1, "m3_ph0");
      tick(3,  0, 0, 1, 24'h7D7D7D, 1, "m3_ph3");
      tick(64, 0, 0, 1, 24'h808080, 1, "m3_band_wrap");
      tick(3,  0, 1, 1, 24'h7D7D7D, 1, "m3_fs2_old");    // offset -> 5
      tick(0,  0, 1, 1, 24'h7B7B7B, 1, "m3_fs3_old");    // offset -> 10
      tick(0,  0, 0, 1, 24'h767676, 1, "m3_off10");
      tick(60, 0, 0, 1, 24'h7A7A7A, 1, "m3_off10_x60");
      tick(-1, 0, 0, 1, 24'h000000, 0, "m3_inact");
      // 202 more pulses: offset = 5*(205-1) = 1020
      for (int i = 0; i < 202; i++) tick(-1, -1, 1, 0, 24'h0, 0, "pre");
      tick(0, 0, 0, 1, 24'h444444, 1, "m3_off1020");
      tick(4, 0, 1, 1, 24'h808080, 1, "m3_fs_wrap_old"); // 1020+5 -> 1
      tick(0, 0, 0, 1, 24'h7F7F7F, 1, "m3_off_wrapped");
      tick(63, 0, 0, 1, 24'h808080, 1, "m3_wrap_x63");
      tick(0, 0, 0, 0, 24'h0, 0, "flush");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
